uart_tx_sampler: RTL and testbench
==================================

Name: uart_tx_sampler

Overview:
- UART transmitter for the TP2 serial link. Serializes one byte per frame as 1 start bit, DBIT data bits LSB first, then a stop period.
- Bit timing comes from the 16x oversampling tick (s_tick) produced by the team's mod-M baud counter (N=8, M=163 at the board clock).
- Sits between the interface/ALU logic that supplies bytes and the tx pin. It is the sending end for the UART receiver fed by the same tick.

Parameters:
- DBIT, 8, number of data bits per frame (valid 5..8).
- SB_TICK, 16, s_ticks in the stop period (16/24/32 = 1/1.5/2 stop bits; max 32).

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- s_tick, input, 1, one-clk-wide oversampling strobe, 16 per bit period.
- tx_start, input, 1, request to send din; sampled only in IDLE.
- din, input, 8, byte to send; only bits [DBIT-1:0] are used.
- tx, output, 1, serial line; idles high.
- tx_busy, output, 1, high while a frame is in progress.
- tx_done_tick, output, 1, one-clk pulse when a frame completes.

Behaviour:
- Reset (reset=0, async, overrides everything):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, tick counter s=0, bit counter n=0, shift register b=0.
  - Outputs take these values immediately, without waiting for clk.
- All outputs are registered and update on the same edge as the state register. There are no combinational paths from inputs to outputs.
- Counters: s is 5 bits, n is 3 bits, b is DBIT bits.
- IDLE:
  - tx=1, tx_busy=0. s_tick is ignored.
  - On an edge with tx_start=1: b<=din[DBIT-1:0], s<=0, go to START. tx becomes 0 and tx_busy becomes 1 on that same edge.
- START:
  - tx=0.
  - On an edge with s_tick=1: if s==15, then s<=0, n<=0, go to DATA (tx<=b[0]); else s<=s+1.
- DATA:
  - tx=b[0].
  - On an edge with s_tick=1 and s==15: s<=0, b<=b>>1.
    - If n==DBIT-1, go to STOP (tx<=1).
    - Else n<=n+1, and tx<=next b[0].
  - On an edge with s_tick=1 and s<15: s<=s+1.
- STOP:
  - tx=1.
  - On an edge with s_tick=1 and s==SB_TICK-1: go to IDLE, tx_busy<=0, tx_done_tick<=1.
  - On an edge with s_tick=1 otherwise: s<=s+1.
- tx_done_tick is high for exactly the one clk cycle after the STOP->IDLE edge, and 0 at all other times.
- Frame length is 16 + 16*DBIT + SB_TICK s_ticks. With defaults this is 160 ticks; at M=163 it is 26080 clks after the accept edge.
- Boundary rules:
  - A tick coincident with the accept edge is not counted; the START count begins with the next tick.
  - tx_start outside IDLE is ignored. The request is not queued.
  - din changes after the accept edge do not affect the frame in flight.
  - Back-to-back frames: if tx_start=1 during the tx_done_tick cycle, the next frame is accepted on the following edge. This gives one clk of tx=1 plus the full stop period between frames.
  - s_tick faster than 1 per clk is impossible. Frame timing scales with the tick spacing only.
  - Reset mid-frame aborts the frame. tx returns high immediately with no done pulse. The next tx_start after reset release sends a complete frame.

Test Plan:
- Reset: hold reset=0 for 10 clks while toggling tx_start/s_tick -> tx=1, tx_busy=0, tx_done_tick=0 throughout; release -> still idle.
- Single byte: tick every 163 clks, din=0xA5, one-clk tx_start -> tx=0 for 16 ticks, then bits 1,0,1,0,0,1,0,1 for 16 ticks each, then 1 for 16 ticks. A single tx_done_tick follows after 160 ticks; tx_busy is high for exactly that span.
- Ignore while busy: start 0x3C, then pulse tx_start with din=0xFF mid-DATA -> line still carries 0x3C and only one done pulse occurs.
- Back-to-back: hold tx_start=1 with din=0x00, then 0xFF (switched on done pulse) -> frames are separated by 1 clk; the second frame is all-ones data and its start bit is intact.
- Reset mid-frame: assert reset during bit 3 of 0x55 -> tx=1 in the same cycle, tx_busy=0, no done pulse; a new start with 0x81 is sent correctly.
- Parameters: DBIT=7, SB_TICK=32, tick every 4 clks -> frame = 16+112+32 = 160 ticks = 640 clks, and the stop level is held for 32 ticks.

Source files
------------

// File: rtl/uart_tx_sampler_if.sv
// Byte-request and serial-line signals between the byte source and the UART transmitter.
// The source drives the tick, request and byte; the transmitter returns the line and status.
`timescale 1ns/1ps
interface uart_tx_sampler_if;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (
    output s_tick, tx_start, din,
    input  tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  s_tick, tx_start, din,
    output tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_sampler.sv
// UART transmitter: 1 start bit, DBIT data bits LSB first, SB_TICK-tick stop period.
// Bit timing follows the 16x oversampling strobe; every output is a register.
`timescale 1ns/1ps
module uart_tx_sampler #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_sampler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] S_LAST  = 5'd15;
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  state_t          state_r, state_s;
  logic [4:0]      s_r, s_next_s;
  logic [2:0]      n_r, n_next_s;
  logic [DBIT-1:0] b_r, b_next_s, b_shift_s;
  logic            tx_r, tx_next_s;
  logic            busy_r, busy_next_s;
  logic            done_r, done_next_s;

  // Next-state and next-output logic; the line level is computed one edge ahead
  always_comb begin
    state_s     = state_r;
    s_next_s    = s_r;
    n_next_s    = n_r;
    b_next_s    = b_r;
    tx_next_s   = tx_r;
    busy_next_s = busy_r;
    done_next_s = 1'b0;
    b_shift_s   = b_r >> 1'b1;

    case (state_r)
      IDLE: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
        if (bus.tx_start) begin
          b_next_s    = bus.din[DBIT-1:0];
          s_next_s    = 5'd0;
          state_s     = START;
          tx_next_s   = 1'b0;
          busy_next_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_r == S_LAST) begin
            s_next_s  = 5'd0;
            n_next_s  = 3'd0;
            state_s   = DATA;
            tx_next_s = b_r[0];
          end else begin
            s_next_s = s_r + 5'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_r == S_LAST) begin
            s_next_s = 5'd0;
            b_next_s = b_shift_s;
            if (n_r == N_LAST) begin
              state_s   = STOP;
              tx_next_s = 1'b1;
            end else begin
              n_next_s  = n_r + 3'd1;
              tx_next_s = b_shift_s[0];
            end
          end else begin
            s_next_s = s_r + 5'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end

      STOP: begin
        tx_next_s = 1'b1;
        if (bus.s_tick) begin
          if (s_r == SB_LAST) begin
            s_next_s    = 5'd0;
            state_s     = IDLE;
            busy_next_s = 1'b0;
            done_next_s = 1'b1;
          end else begin
            s_next_s = s_r + 5'd1;
          end
        end else begin
          s_next_s = s_r;
        end
      end

      default: begin
        state_s     = IDLE;
        s_next_s    = 5'd0;
        n_next_s    = 3'd0;
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces the idle line at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      s_r     <= 5'd0;
      n_r     <= 3'd0;
      b_r     <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      s_r     <= s_next_s;
      n_r     <= n_next_s;
      b_r     <= b_next_s;
      tx_r    <= tx_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  assign bus.tx           = tx_r;
  assign bus.tx_busy      = busy_r;
  assign bus.tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_sampler.sv
// Scoreboard bench for uart_tx_sampler: stimulus queues expected bytes, a line
// monitor decodes each frame tick by tick and checks level, timing and done pulse.
`timescale 1ns/1ps
module tb_uart_tx_sampler;

  logic clk;
  logic reset;

  uart_tx_sampler_if if0 ();
  uart_tx_sampler_if if1 ();

  uart_tx_sampler u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  uart_tx_sampler #(.DBIT(7), .SB_TICK(32)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int comp_cnt = 0;
  int err_cnt  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int         tick_div0 = 2;
  int         tick_div1 = 4;
  int         m_act[2];
  int         m_cnt[2];
  int         m_bad[2];
  int         m_total[2];
  int         m_dbit[2];
  int         dones[2];
  logic [7:0] m_exp[2];
  logic [7:0] m_dec[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    comp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick generators: s_tick high for one clk every tick_divN clks
  initial begin
    int tcnt;
    tcnt = 0;
    if0.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tcnt >= tick_div0 - 1) begin
        tcnt = 0;
        if0.s_tick = 1'b1;
      end else begin
        tcnt++;
        if0.s_tick = 1'b0;
      end
    end
  end

  initial begin
    int tcnt;
    tcnt = 0;
    if1.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tcnt >= tick_div1 - 1) begin
        tcnt = 0;
        if1.s_tick = 1'b1;
      end else begin
        tcnt++;
        if1.s_tick = 1'b0;
      end
    end
  end

  // One monitor step per falling edge; m_cnt is the number of ticks consumed since the start edge
  task automatic mon_step(input int ch, input logic rstn, input logic tx, input logic busy,
                          input logic done, input logic tick);
    int   idx;
    logic lvl;
    if (!rstn) begin
      m_act[ch] = 0;
      return;
    end
    if (done) dones[ch]++;
    if (m_act[ch] == 0 && tx == 1'b0) begin
      m_act[ch] = 1;
      m_cnt[ch] = 0;
      m_bad[ch] = 0;
      m_dec[ch] = 8'h00;
      check($sformatf("ch%0d_frame_expected", ch), ((ch == 0) ? q0.size() : q1.size()) > 0, 1);
      m_exp[ch] = 8'h00;
      if (ch == 0 && q0.size() > 0) m_exp[ch] = q0.pop_front();
      if (ch == 1 && q1.size() > 0) m_exp[ch] = q1.pop_front();
    end
    if (m_act[ch] != 0) begin
      if (m_cnt[ch] < m_total[ch]) begin
        if (m_cnt[ch] < 16) begin
          lvl = 1'b0;
        end else if (m_cnt[ch] < 16 + 16 * m_dbit[ch]) begin
          idx = (m_cnt[ch] - 16) / 16;
          lvl = m_exp[ch][idx];
          if ((m_cnt[ch] % 16) == 8) m_dec[ch][idx] = tx;
        end else begin
          lvl = 1'b1;
        end
        if (tx !== lvl || busy !== 1'b1 || done !== 1'b0) m_bad[ch]++;
        if (tick) m_cnt[ch]++;
      end else begin
        check($sformatf("ch%0d_frame_shape", ch), m_bad[ch], 0);
        check($sformatf("ch%0d_frame_data", ch), m_dec[ch], m_exp[ch]);
        check($sformatf("ch%0d_done_at_end", ch), {tx, busy, done}, 3'b101);
        m_act[ch] = 0;
      end
    end
  endtask

  // Scoreboard monitor for both transmitters
  always @(negedge clk) begin
    mon_step(0, reset, if0.tx, if0.tx_busy, if0.tx_done_tick, if0.s_tick);
    mon_step(1, reset, if1.tx, if1.tx_busy, if1.tx_done_tick, if1.s_tick);
  end

  task automatic send(input int ch, input logic [7:0] d, input logic [7:0] exp);
    if (ch == 0) begin
      q0.push_back(exp);
      if0.din = d;
      if0.tx_start = 1'b1;
    end else begin
      q1.push_back(exp);
      if1.din = d;
      if1.tx_start = 1'b1;
    end
    @(posedge clk);
    #1;
    if0.tx_start = 1'b0;
    if1.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int bound);
    int   k;
    logic d;
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      d = (ch == 0) ? if0.tx_done_tick : if1.tx_done_tick;
      if (d) break;
    end
    check($sformatf("ch%0d_done_within_bound", ch), k < bound, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    m_act   = '{0, 0};
    m_cnt   = '{0, 0};
    m_bad   = '{0, 0};
    dones   = '{0, 0};
    m_total = '{160, 160};
    m_dbit  = '{8, 7};
    m_exp   = '{8'h00, 8'h00};
    m_dec   = '{8'h00, 8'h00};

    // Reset held with request and ticks active: line must stay idle
    reset = 1'b0;
    if0.tx_start = 1'b1; if0.din = 8'hA5;
    if1.tx_start = 1'b1; if1.din = 8'h7F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle0", {if0.tx, if0.tx_busy, if0.tx_done_tick}, 3'b100);
      check("reset_idle1", {if1.tx, if1.tx_busy, if1.tx_done_tick}, 3'b100);
    end
    if0.tx_start = 1'b0;
    if1.tx_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle0", {if0.tx, if0.tx_busy, if0.tx_done_tick}, 3'b100);
    check("post_reset_idle1", {if1.tx, if1.tx_busy, if1.tx_done_tick}, 3'b100);

    // Single byte 0xA5 at the board tick rate; din changes after accept must not matter
    tick_div0 = 163;
    send(0, 8'hA5, 8'hA5);
    if0.din = 8'h00;
    wait_done(0, 160 * 163 + 400);
    repeat (20) @(negedge clk);
    check("done_count_single", dones[0], 1);
    check("idle_after_single", {if0.tx, if0.tx_busy, if0.tx_done_tick}, 3'b100);

    // Request during DATA is ignored
    tick_div0 = 16;
    send(0, 8'h3C, 8'h3C);
    repeat ((16 + 16 * 2 + 8) * 16) @(negedge clk);
    @(posedge clk); #1;
    if0.din = 8'hFF;
    if0.tx_start = 1'b1;
    @(posedge clk); #1;
    if0.tx_start = 1'b0;
    wait_done(0, 160 * 16 + 100);
    repeat (40) @(negedge clk);
    check("done_count_ignore", dones[0], 2);
    check("idle_after_ignore", {if0.tx, if0.tx_busy}, 2'b10);

    // Back-to-back: 0x00 then 0xFF with tx_start held, din switched on the done pulse
    q0.push_back(8'h00);
    if0.din = 8'h00;
    if0.tx_start = 1'b1;
    wait_done(0, 160 * 16 + 100);
    if0.din = 8'hFF;
    q0.push_back(8'hFF);
    @(posedge clk); #1;
    if0.tx_start = 1'b0;
    check("b2b_gap_start", {if0.tx, if0.tx_busy}, 2'b01);
    wait_done(0, 160 * 16 + 100);
    repeat (20) @(negedge clk);
    check("done_count_b2b", dones[0], 4);

    // Reset during bit 3 of 0x55 aborts the frame without a done pulse
    send(0, 8'h55, 8'h55);
    repeat ((16 + 16 * 3 + 8) * 16) @(negedge clk);
    check("pre_abort_line_low", if0.tx, 1'b0);
    reset = 1'b0;
    #1;
    check("abort_immediate", {if0.tx, if0.tx_busy, if0.tx_done_tick}, 3'b100);
    repeat (5) begin
      @(negedge clk);
      check("abort_hold", {if0.tx, if0.tx_busy, if0.tx_done_tick}, 3'b100);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("done_count_abort", dones[0], 4);
    send(0, 8'h81, 8'h81);
    wait_done(0, 160 * 16 + 100);
    repeat (20) @(negedge clk);
    check("done_count_after_abort", dones[0], 5);

    // Seven data bits, two stop bits, tick every 4 clks: 0xD3 carries 0x53 on the line
    send(1, 8'hD3, 8'h53);
    wait_done(1, 640 + 100);
    repeat (20) @(negedge clk);
    check("done_count_dbit7", dones[1], 1);
    check("idle_after_dbit7", {if1.tx, if1.tx_busy, if1.tx_done_tick}, 3'b100);

    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
    $finish;
  end

endmodule
